// File: rtl/pmp_pkg.sv
// Shared definitions for the machine-mode PMP/ePMP CSR bank.
// Holds the CSR address map, the pmpcfg A-field encoding and the bit
// positions inside a pmpcfg byte and inside mseccfg.
package pmp_pkg;

    // CSR addresses
    localparam logic [11:0] PMPCFG0      = 12'h3A0;
    localparam logic [11:0] PMPADDR0     = 12'h3B0;
    localparam logic [11:0] PMPADDR_LAST = 12'h3EF;
    localparam logic [11:0] MSECCFG      = 12'h747;
    localparam logic [11:0] MSECCFGH     = 12'h757;

    // Address-matching mode held in pmpcfg.A
    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_a_e;

    // Bit positions inside one pmpcfg byte
    localparam int CFG_L    = 7;
    localparam int CFG_A_HI = 4;
    localparam int CFG_A_LO = 3;
    localparam int CFG_X    = 2;
    localparam int CFG_W    = 1;
    localparam int CFG_R    = 0;

    // Bit positions inside mseccfg
    localparam int MSEC_MML  = 0;
    localparam int MSEC_MMWP = 1;
    localparam int MSEC_RLB  = 2;

endpackage

// File: rtl/pmp_cfg_legalize.sv
// Legalises one pmpcfg byte write.
// Ports:
//   old_cfg   - currently stored byte
//   new_cfg   - byte being written
//   mml, rlb  - current mseccfg.MML / mseccfg.RLB
//   legal_cfg - byte to store if the write is accepted
//   write_ok  - 1 when the byte may be updated (not locked, not an
//               MML-forbidden locked rule)
module pmp_cfg_legalize
    import pmp_pkg::*;
#(
    parameter int PMP_G = 0
) (
    input  logic [7:0] old_cfg,
    input  logic [7:0] new_cfg,
    input  logic       mml,
    input  logic       rlb,
    output logic [7:0] legal_cfg,
    output logic       write_ok
);

    logic [1:0] a_s;
    logic       rw_clear_s;
    logic       mml_drop_s;
    logic       locked_s;

    // Field legalisation and accept decision for one byte
    always_comb begin
        // NA4 cannot be expressed when the grain exceeds 4 bytes, keep old mode
        a_s = ((PMP_G > 0) && (new_cfg[CFG_A_HI:CFG_A_LO] == NA4))
              ? old_cfg[CFG_A_HI:CFG_A_LO] : new_cfg[CFG_A_HI:CFG_A_LO];
        // Write-only is reserved unless MML gives it a meaning
        rw_clear_s = ~mml & ~new_cfg[CFG_R] & new_cfg[CFG_W];
        legal_cfg  = {new_cfg[CFG_L], 2'b00, a_s, new_cfg[CFG_X],
                      new_cfg[CFG_W] & ~rw_clear_s, new_cfg[CFG_R]};
        // Under MML, locked executable or locked shared-data rules need RLB
        mml_drop_s = mml & ~rlb & new_cfg[CFG_L]
                     & (new_cfg[CFG_X] | (~new_cfg[CFG_R] & new_cfg[CFG_W]));
        locked_s   = old_cfg[CFG_L] & ~rlb;
        write_ok   = ~locked_s & ~mml_drop_s;
    end

endmodule

// File: rtl/pmp_csr_bank.sv
// Machine-mode PMP/ePMP CSR bank: pmpcfg*, pmpaddr* and mseccfg.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   CSRWriteM           - committed CSR write this cycle
//   CSRAdrM             - CSR address
//   CSRWriteValM        - write data
//   HitM                - address belongs to this bank
//   CSRReadValM         - combinational read data (0 when not hit/illegal)
//   IllegalAccessM      - hit but illegal access
//   PMPCFG_ARRAY_REGW   - packed cfg bytes, entry i at [8i+7:8i]
//   PMPADDR_ARRAY_REGW  - grain-aligned pmpaddr values
//   MSECCFG_MML/MMWP/RLB- ePMP control bits
//   PMPUpdateW          - one-cycle pulse after any effective state change
module pmp_csr_bank
    import pmp_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int PA_BITS          = 56,
    parameter int PMP_ENTRIES      = 16,
    parameter int PMP_G            = 0,
    parameter int SMEPMP_SUPPORTED = 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                CSRWriteM,
    input  logic [11:0]                         CSRAdrM,
    input  logic [XLEN-1:0]                     CSRWriteValM,
    output logic                                HitM,
    output logic [XLEN-1:0]                     CSRReadValM,
    output logic                                IllegalAccessM,
    output logic [8*PMP_ENTRIES-1:0]            PMPCFG_ARRAY_REGW,
    output logic [(PA_BITS-2)*PMP_ENTRIES-1:0]  PMPADDR_ARRAY_REGW,
    output logic                                MSECCFG_MML,
    output logic                                MSECCFG_MMWP,
    output logic                                MSECCFG_RLB,
    output logic                                PMPUpdateW
);

    localparam int   AW         = PA_BITS - 2;
    // Storage keeps at least one (never written) entry so arrays stay legal
    localparam int   NE         = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
    localparam int   CPR        = XLEN / 8;
    localparam logic IS_RV64    = (XLEN == 64);
    localparam logic HAS_SMEPMP = (SMEPMP_SUPPORTED != 0);

    // Read value of pmpaddr as seen through the grain
    function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] raw,
                                                 input logic napot);
        logic [AW-1:0] res;
        res = raw;
        for (int j = 0; j < AW; j++) begin
            if (napot && (j <= PMP_G - 2)) begin
                res[j] = 1'b1;
            end else if (!napot && (j < PMP_G)) begin
                res[j] = 1'b0;
            end else begin
                res[j] = raw[j];
            end
        end
        return res;
    endfunction

    logic [7:0]      cfg_r        [NE];
    logic [AW-1:0]   addr_r       [NE];
    logic            mml_r, mmwp_r, rlb_r, update_r;

    logic [7:0]      cfg_next_s   [NE];
    logic [AW-1:0]   addr_next_s  [NE];
    logic [AW-1:0]   addr_align_s [NE];
    logic [7:0]      cfg_wbyte_s  [NE];
    logic [7:0]      cfg_legal_s  [NE];
    logic [6:0]      cfg_off_s    [NE];
    logic [NE-1:0]   cfg_sel_s;
    logic [NE-1:0]   cfg_ok_s;
    logic [NE:0]     lk_s;
    logic [NE:0]     tor_s;
    logic            any_l_s;
    logic            mml_next_s, mmwp_next_s, rlb_next_s, update_s;

    logic            is_cfg_s, is_addr_s, is_msec_s, is_msech_s;
    logic            hit_s, illegal_s, wr_en_s;
    logic [5:0]      cfg_base_s;
    logic [5:0]      addr_idx_s;
    logic [XLEN-1:0] rd_s;

    // Address decode and legality of the current access
    always_comb begin
        is_cfg_s   = (CSRAdrM[11:4] == PMPCFG0[11:4]);
        is_addr_s  = (CSRAdrM >= PMPADDR0) && (CSRAdrM <= PMPADDR_LAST);
        is_msec_s  = (CSRAdrM == MSECCFG);
        is_msech_s = (CSRAdrM == MSECCFGH);
        hit_s      = is_cfg_s | is_addr_s | is_msec_s | is_msech_s;
        // pmpcfgN covers entries from 4N on both RV32 and RV64 (N even on RV64)
        cfg_base_s = {CSRAdrM[3:0], 2'b00};
        addr_idx_s = 6'(CSRAdrM - PMPADDR0);
        if (is_cfg_s) begin
            illegal_s = IS_RV64 & CSRAdrM[0];
        end else if (is_msec_s) begin
            illegal_s = ~HAS_SMEPMP;
        end else if (is_msech_s) begin
            illegal_s = IS_RV64 | ~HAS_SMEPMP;
        end else begin
            illegal_s = 1'b0;
        end
        wr_en_s = CSRWriteM & hit_s & ~illegal_s;
    end

    // Per-entry lock view and byte lane selection for pmpcfg writes
    always_comb begin
        lk_s    = {(NE+1){1'b0}};
        tor_s   = {(NE+1){1'b0}};
        any_l_s = 1'b0;
        for (int i = 0; i < NE; i++) begin
            if (i < PMP_ENTRIES) begin
                lk_s[i]  = cfg_r[i][CFG_L] & ~rlb_r;
                tor_s[i] = (cfg_r[i][CFG_A_HI:CFG_A_LO] == TOR);
                any_l_s  = any_l_s | cfg_r[i][CFG_L];
            end else begin
                lk_s[i]  = 1'b0;
                tor_s[i] = 1'b0;
            end
            cfg_off_s[i]   = 7'(i) - {1'b0, cfg_base_s};
            cfg_sel_s[i]   = (7'(i) >= {1'b0, cfg_base_s}) && (cfg_off_s[i] < 7'(CPR))
                             && (i < PMP_ENTRIES);
            cfg_wbyte_s[i] = 8'(CSRWriteValM >> {cfg_off_s[i][2:0], 3'b000});
        end
    end

    // One legaliser per entry
    for (genvar g = 0; g < NE; g++) begin : g_legal
        pmp_cfg_legalize #(.PMP_G(PMP_G)) u_legal (
            .old_cfg   (cfg_r[g]),
            .new_cfg   (cfg_wbyte_s[g]),
            .mml       (mml_r),
            .rlb       (rlb_r),
            .legal_cfg (cfg_legal_s[g]),
            .write_ok  (cfg_ok_s[g])
        );
    end

    // Next state of every register and detection of an effective change
    always_comb begin
        if (wr_en_s && is_msec_s && HAS_SMEPMP) begin
            // MML/MMWP are sticky; RLB cannot be raised while any rule is locked
            mml_next_s  = mml_r  | CSRWriteValM[MSEC_MML];
            mmwp_next_s = mmwp_r | CSRWriteValM[MSEC_MMWP];
            rlb_next_s  = CSRWriteValM[MSEC_RLB] & (rlb_r | ~any_l_s);
        end else begin
            mml_next_s  = mml_r;
            mmwp_next_s = mmwp_r;
            rlb_next_s  = rlb_r;
        end
        update_s = (mml_next_s != mml_r) | (mmwp_next_s != mmwp_r) | (rlb_next_s != rlb_r);
        for (int i = 0; i < NE; i++) begin
            if (wr_en_s && is_cfg_s && cfg_sel_s[i] && cfg_ok_s[i]) begin
                cfg_next_s[i] = cfg_legal_s[i];
            end else begin
                cfg_next_s[i] = cfg_r[i];
            end
            // A TOR rule above also freezes this address as its lower bound
            if (wr_en_s && is_addr_s && (addr_idx_s == 6'(i)) && (i < PMP_ENTRIES)
                && !(lk_s[i] | (lk_s[i+1] & tor_s[i+1]))) begin
                addr_next_s[i] = AW'(CSRWriteValM);
            end else begin
                addr_next_s[i] = addr_r[i];
            end
            update_s = update_s | (cfg_next_s[i] != cfg_r[i]) | (addr_next_s[i] != addr_r[i]);
        end
    end

    // Grain-aligned address view, shared by reads and the checker export
    always_comb begin
        for (int i = 0; i < NE; i++) begin
            addr_align_s[i] = align_addr(addr_r[i], cfg_r[i][CFG_A_HI]);
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_s = {XLEN{1'b0}};
        if (!hit_s || illegal_s) begin
            rd_s = {XLEN{1'b0}};
        end else if (is_cfg_s) begin
            for (int i = 0; i < NE; i++) begin
                rd_s = rd_s | (cfg_sel_s[i]
                       ? (XLEN'(cfg_r[i]) << {cfg_off_s[i][2:0], 3'b000}) : {XLEN{1'b0}});
            end
        end else if (is_addr_s) begin
            for (int i = 0; i < NE; i++) begin
                rd_s = rd_s | (((addr_idx_s == 6'(i)) && (i < PMP_ENTRIES))
                       ? XLEN'(addr_align_s[i]) : {XLEN{1'b0}});
            end
        end else if (is_msec_s) begin
            rd_s = XLEN'({rlb_r, mmwp_r, mml_r});
        end else begin
            rd_s = {XLEN{1'b0}};
        end
    end

    // State registers and the registered update pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NE; i++) begin
                cfg_r[i]  <= 8'h00;
                addr_r[i] <= {AW{1'b0}};
            end
            mml_r    <= 1'b0;
            mmwp_r   <= 1'b0;
            rlb_r    <= 1'b0;
            update_r <= 1'b0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                cfg_r[i]  <= cfg_next_s[i];
                addr_r[i] <= addr_next_s[i];
            end
            mml_r    <= mml_next_s;
            mmwp_r   <= mmwp_next_s;
            rlb_r    <= rlb_next_s;
            update_r <= update_s;
        end
    end

    assign HitM           = hit_s;
    assign IllegalAccessM = hit_s & illegal_s;
    assign CSRReadValM    = rd_s;
    assign MSECCFG_MML    = mml_r;
    assign MSECCFG_MMWP   = mmwp_r;
    assign MSECCFG_RLB    = rlb_r;
    assign PMPUpdateW     = update_r;

    if (PMP_ENTRIES > 0) begin : g_out
        for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_ent
            assign PMPCFG_ARRAY_REGW[8*g +: 8]    = cfg_r[g];
            assign PMPADDR_ARRAY_REGW[AW*g +: AW] = addr_align_s[g];
        end
    end else begin : g_none
        assign PMPCFG_ARRAY_REGW  = '0;
        assign PMPADDR_ARRAY_REGW = '0;
    end

endmodule
